// File: rtl/rv_fetch_queue.sv
// Circular halfword fetch queue: realigns 16/32-bit instructions across the ring boundary.
// Define RV_FETCH_QUEUE_BYPASS_EN to present a pushed instruction in the same cycle when empty.
module rv_fetch_queue #(
    parameter int                          IADDR_SPACE_BITS = 16,
    parameter int                          DEPTH_BITS       = 3,
    parameter logic [IADDR_SPACE_BITS-2:0] RESET_PC         = '0
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_flush,
    input  logic [IADDR_SPACE_BITS-2:0]   i_flush_pc,
    input  logic                          i_push_valid,
    input  logic                          i_push_double,
    input  logic [15:0]                   i_data_lo,
    input  logic [15:0]                   i_data_hi,
    output logic                          o_push_ready,
    output logic                          o_valid,
    output logic [31:0]                   o_instr,
    output logic                          o_is_comp,
    output logic [IADDR_SPACE_BITS-2:0]   o_pc,
    output logic [IADDR_SPACE_BITS-2:0]   o_pc_next,
    input  logic                          i_pop,
    output logic [DEPTH_BITS:0]           o_count
);

    localparam int                          DEPTH     = 2 ** DEPTH_BITS;
    localparam logic [DEPTH_BITS:0]         READY_MAX = (DEPTH_BITS + 1)'(DEPTH - 2);
    localparam logic [DEPTH_BITS:0]         CNT_ONE   = (DEPTH_BITS + 1)'(1);
    localparam logic [DEPTH_BITS:0]         CNT_TWO   = (DEPTH_BITS + 1)'(2);
    localparam logic [DEPTH_BITS-1:0]       PTR_ONE   = DEPTH_BITS'(1);
    localparam logic [IADDR_SPACE_BITS-2:0] PC_ONE    = (IADDR_SPACE_BITS - 1)'(1);
    localparam logic [IADDR_SPACE_BITS-2:0] PC_TWO    = (IADDR_SPACE_BITS - 1)'(2);

    logic [15:0]                 mem [DEPTH];
    logic [DEPTH_BITS-1:0]       rd_ptr;
    logic [DEPTH_BITS-1:0]       wr_ptr;
    logic [DEPTH_BITS-1:0]       rd_ptr_p1;
    logic [DEPTH_BITS-1:0]       wr_ptr_p1;
    logic [DEPTH_BITS:0]         count;
    logic [DEPTH_BITS:0]         push_amt;
    logic [DEPTH_BITS:0]         pop_amt;
    logic [IADDR_SPACE_BITS-2:0] pc;
    logic [15:0]                 h0;
    logic [15:0]                 h1;
    logic                        q_comp;
    logic                        q_valid;
    logic [31:0]                 q_instr;
    logic                        push_acc;
    logic                        pop_acc;

    assign rd_ptr_p1 = rd_ptr + PTR_ONE;
    assign wr_ptr_p1 = wr_ptr + PTR_ONE;
    assign h0        = mem[rd_ptr];
    assign h1        = mem[rd_ptr_p1];
    assign q_comp    = (h0[1:0] != 2'b11);
    assign q_valid   = q_comp ? (count != '0) : (count >= CNT_TWO);
    assign q_instr   = q_comp ? {16'h0000, h0} : {h1, h0};

    assign o_push_ready = (count <= READY_MAX);
    assign o_count      = count;
    assign o_pc         = pc;
    assign o_pc_next    = pc + (o_is_comp ? PC_ONE : PC_TWO);

    assign push_acc = i_push_valid & o_push_ready & ~i_flush;
    assign pop_acc  = i_pop & o_valid & ~i_flush;
    assign push_amt = push_acc ? (i_push_double ? CNT_TWO : CNT_ONE) : '0;
    assign pop_amt  = pop_acc ? (o_is_comp ? CNT_ONE : CNT_TWO) : '0;

`ifdef RV_FETCH_QUEUE_BYPASS_EN
    logic        byp_sel;
    logic [15:0] byp_first;
    logic        byp_comp;

    assign byp_sel   = (count == '0) & push_acc;
    assign byp_first = i_push_double ? i_data_lo : i_data_hi;
    assign byp_comp  = (byp_first[1:0] != 2'b11);

    always_comb begin
        o_valid   = q_valid;
        o_is_comp = q_comp;
        o_instr   = q_instr;
        if (byp_sel) begin
            o_valid   = byp_comp | i_push_double;
            o_is_comp = byp_comp;
            o_instr   = byp_comp ? {16'h0000, byp_first} : {i_data_hi, i_data_lo};
        end
    end
`else
    always_comb begin
        o_valid   = q_valid;
        o_is_comp = q_comp;
        o_instr   = q_instr;
    end
`endif

    // In the bypass case the consumed halfwords are still written; rd_ptr simply steps over them.
    always_ff @(posedge i_clk) begin
        if (push_acc) begin
            if (i_push_double) begin
                mem[wr_ptr]    <= i_data_lo;
                mem[wr_ptr_p1] <= i_data_hi;
            end else begin
                mem[wr_ptr] <= i_data_hi;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pc     <= RESET_PC;
        end else if (i_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pc     <= i_flush_pc;
        end else begin
            wr_ptr <= wr_ptr + push_amt[DEPTH_BITS-1:0];
            rd_ptr <= rd_ptr + pop_amt[DEPTH_BITS-1:0];
            count  <= count + push_amt - pop_amt;
            if (pop_acc) begin
                pc <= o_pc_next;
            end
        end
    end

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Bench for rv_fetch_queue: directed scenarios plus random traffic against a halfword-queue model.
module tb_rv_fetch_queue;

    localparam int         DEPTH_BITS = 3;
    localparam int         DEPTH      = 2 ** DEPTH_BITS;
    localparam logic [14:0] RST_PC    = 15'h40;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_flush;
    logic [14:0] i_flush_pc;
    logic        i_push_valid;
    logic        i_push_double;
    logic [15:0] i_data_lo;
    logic [15:0] i_data_hi;
    logic        o_push_ready;
    logic        o_valid;
    logic [31:0] o_instr;
    logic        o_is_comp;
    logic [14:0] o_pc;
    logic [14:0] o_pc_next;
    logic        i_pop;
    logic [DEPTH_BITS:0] o_count;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] mq[$];
    logic [14:0] mpc;

    rv_fetch_queue #(
        .IADDR_SPACE_BITS(16),
        .DEPTH_BITS(DEPTH_BITS),
        .RESET_PC(RST_PC)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_flush(i_flush),
        .i_flush_pc(i_flush_pc),
        .i_push_valid(i_push_valid),
        .i_push_double(i_push_double),
        .i_data_lo(i_data_lo),
        .i_data_hi(i_data_hi),
        .o_push_ready(o_push_ready),
        .o_valid(o_valid),
        .o_instr(o_instr),
        .o_is_comp(o_is_comp),
        .o_pc(o_pc),
        .o_pc_next(o_pc_next),
        .i_pop(i_pop),
        .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic [14:0] fpc, input logic pv, input logic pd,
                         input logic [15:0] lo, input logic [15:0] hi, input logic pp);
        i_flush       = fl;
        i_flush_pc    = fpc;
        i_push_valid  = pv;
        i_push_double = pd;
        i_data_lo     = lo;
        i_data_hi     = hi;
        i_pop         = pp;
    endtask

    task automatic idle();
        drive(1'b0, 15'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model with the edge.
    task automatic step();
        logic [15:0] v[$];
        logic [15:0] hw0;
        int          e_cnt;
        logic        e_rdy;
        logic        push_ok;
        logic        e_valid;
        logic        e_comp;
        logic [31:0] e_instr;
        logic [14:0] e_next;
        @(negedge i_clk);
        e_cnt   = mq.size();
        e_rdy   = (e_cnt <= DEPTH - 2);
        push_ok = i_push_valid && e_rdy && !i_flush;
        v = mq;
`ifdef RV_FETCH_QUEUE_BYPASS_EN
        if (e_cnt == 0 && push_ok) begin
            if (i_push_double) v.push_back(i_data_lo);
            v.push_back(i_data_hi);
        end
`endif
        e_valid = 1'b0;
        e_comp  = 1'b0;
        e_instr = 32'h0;
        if (v.size() > 0) begin
            hw0    = v[0];
            e_comp = (hw0[1:0] != 2'b11);
            if (e_comp) begin
                e_valid = 1'b1;
                e_instr = {16'h0000, hw0};
            end else if (v.size() >= 2) begin
                e_valid = 1'b1;
                e_instr = {v[1], hw0};
            end
        end
        e_next = mpc + (e_comp ? 15'd1 : 15'd2);
        chk("count", 32'(o_count), 32'(e_cnt));
        chk("push_ready", 32'(o_push_ready), 32'(e_rdy));
        chk("valid", 32'(o_valid), 32'(e_valid));
        chk("pc", 32'(o_pc), 32'(mpc));
        if (e_valid) begin
            chk("instr", o_instr, e_instr);
            chk("is_comp", 32'(o_is_comp), 32'(e_comp));
            chk("pc_next", 32'(o_pc_next), 32'(e_next));
        end
        if (i_flush) begin
            mq.delete();
            mpc = i_flush_pc;
        end else begin
            if (push_ok) begin
                if (i_push_double) mq.push_back(i_data_lo);
                mq.push_back(i_data_hi);
            end
            if (i_pop && e_valid) begin
                repeat (e_comp ? 1 : 2) void'(mq.pop_front());
                mpc = e_next;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        idle();
        i_reset = 1'b1;
        mq.delete();
        mpc = RST_PC;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;

        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_push_ready), 32'd1);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_pc", 32'(o_pc), 32'h40);

        // first instruction after reset, then reset mid-cycle
        drive(1'b0, 15'h0, 1'b1, 1'b1, 16'h0001, 16'h4501, 1'b0);
        step();
        idle();
        #1;
        chk("r_valid", 32'(o_valid), 32'd1);
        chk("r_comp", 32'(o_is_comp), 32'd1);
        chk("r_instr", o_instr, 32'h0000_0001);
        chk("r_pc", 32'(o_pc), 32'h40);
        chk("r_pc_next", 32'(o_pc_next), 32'h41);
        drive(1'b0, 15'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        step();
        idle();
        #2;
        i_reset = 1'b1;
        #1;
        chk("async_valid", 32'(o_valid), 32'd0);
        chk("async_count", 32'(o_count), 32'd0);
        chk("async_ready", 32'(o_push_ready), 32'd1);
        chk("async_pc", 32'(o_pc), 32'h40);
        mq.delete();
        mpc = RST_PC;
        @(negedge i_clk);
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;

        // mixed 32-bit / compressed stream
        drive(1'b0, 15'h0, 1'b1, 1'b1, 16'h0093, 16'h0010, 1'b0);
        step();
        idle();
        #1;
        chk("mix_instr0", o_instr, 32'h0010_0093);
        chk("mix_pc0", 32'(o_pc), 32'h40);
        drive(1'b0, 15'h0, 1'b1, 1'b0, 16'h0000, 16'h4505, 1'b1);
        step();
        idle();
        #1;
        chk("mix_instr1", o_instr, 32'h0000_4505);
        chk("mix_pc1", 32'(o_pc), 32'h42);

        // flush with simultaneous push and pop
        drive(1'b0, 15'h0, 1'b1, 1'b1, 16'h0001, 16'h0005, 1'b0);
        step();
        drive(1'b1, 15'h100, 1'b1, 1'b1, 16'h1111, 16'h2221, 1'b1);
        step();
        idle();
        #1;
        chk("fl_count", 32'(o_count), 32'd0);
        chk("fl_valid", 32'(o_valid), 32'd0);
        chk("fl_pc", 32'(o_pc), 32'h100);

        // fill to DEPTH-1, hold push, then drain to leave pointers at the last index
        for (int i = 0; i < DEPTH - 1; i++) begin
            drive(1'b0, 15'h0, 1'b1, 1'b0, 16'h0, 16'h4501, 1'b0);
            step();
        end
        drive(1'b0, 15'h0, 1'b1, 1'b0, 16'h0, 16'h4509, 1'b0);
        step();
        #1;
        chk("full_ready", 32'(o_push_ready), 32'd0);
        chk("full_count", 32'(o_count), 32'(DEPTH - 1));
        drive(1'b0, 15'h0, 1'b1, 1'b0, 16'h0, 16'h4509, 1'b1);
        step();
        idle();
        #1;
        chk("full_pop_count", 32'(o_count), 32'(DEPTH - 2));
        chk("full_pop_ready", 32'(o_push_ready), 32'd1);
        for (int i = 0; i < DEPTH - 2; i++) begin
            drive(1'b0, 15'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
            step();
        end
        drive(1'b0, 15'h0, 1'b1, 1'b1, 16'h00A3, 16'h00B1, 1'b0);
        step();
        idle();
        #1;
        chk("wrap_instr", o_instr, 32'h00B1_00A3);
        chk("wrap_valid", 32'(o_valid), 32'd1);
        drive(1'b0, 15'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        step();

        // same-cycle bypass from an empty queue
        drive(1'b0, 15'h0, 1'b1, 1'b1, 16'h4501, 16'h4505, 1'b1);
        #1;
`ifdef RV_FETCH_QUEUE_BYPASS_EN
        chk("byp_valid", 32'(o_valid), 32'd1);
        chk("byp_instr", o_instr, 32'h0000_4501);
`else
        chk("byp_valid", 32'(o_valid), 32'd0);
`endif
        step();
        idle();
        #1;
`ifdef RV_FETCH_QUEUE_BYPASS_EN
        chk("byp_count", 32'(o_count), 32'd1);
        chk("byp_next", o_instr, 32'h0000_4505);
`else
        chk("byp_count", 32'(o_count), 32'd2);
        chk("byp_next", o_instr, 32'h0000_4501);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 31) == 0), 15'($urandom),
                  ($urandom_range(0, 9) < 6), 1'($urandom),
                  16'($urandom), 16'($urandom), ($urandom_range(0, 9) < 6));
            step();
        end
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
